ds_mod_da: RTL
==============

# ds_mod_da

Delta-sigma DAC modulator: accepts 16-bit signed audio/baseband samples at the frame rate and produces a 1-bit PDM bitstream at RATE× oversampling, advancing one bit per `cke` pulse. Linear interpolation (exact, fixed-point) bridges frame rate to bit rate, followed by a 2nd-order CIFB modulator. It is the transmit counterpart of the delta-sigma ADC front end and shares its clock-enable pacing and ±full-scale feedback convention. `pdm_out` drives an external RC or class-D stage.

## Interface
- RATE, 8, oversampling ratio; power of two, 2..64; L = log2(RATE)
- WIDTH, 16, input sample width (fixed 16 in this revision)
- CLIP, 24576, input magnitude clamp (0.75 FS), guarantees modulator stability
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- cke  in  1  bit-rate enable; one PDM bit per high cycle
- din  in  16  signed input sample
- din_valid  in  1  din qualifier
- din_ready  out  1  high when the holding register is empty
- pdm_out  out  1  PDM bit; 1 = +FS, 0 = −FS
- underrun  out  1  one-cycle pulse when a frame starts with no sample held

## Operation
- Holding register (1 entry): handshake on `din_valid && din_ready` in any cycle (independent of `cke`); `din` clamped to [−CLIP, +CLIP] on capture; `din_ready` deasserts next cycle.
- Phase counter `ph` (L bits) counts `cke` pulses; a frame starts on the `cke` where `ph == 0`.
- Frame start: if held, `cur <= held`, holding register emptied (`din_ready` high next cycle); else `cur` unchanged and `underrun` pulses. `prev <= old cur`; `diff <= cur_new − prev_new` (17 bit); `acc <= prev_new << L`.
- Each `cke` inside the frame (including the start): `acc += diff`; interpolated value `x = acc >>> L`. After RATE pulses `acc == cur << L` exactly; no drift.
- Simultaneous capture and frame start in the same cycle: frame uses the previously held state; new capture occupies the register afterwards.
- Modulator, per `cke`, FB = 32768, 24-bit signed integrators saturating at their limits:
  - `fb = pdm_out ? +FB : −FB`
  - `i1 += x − fb`
  - `i2 += i1 − fb`
  - `pdm_out <= (i2 >= 0)`
- `cke` low: all state holds; only the input handshake remains live.
- Reset values: `pdm_out` = 0, `din_ready` = 1, `underrun` = 0, `ph` = 0; `cur`/`prev`/`acc`/`diff`/`i1`/`i2` = 0; holding register empty.

## Timing
- `pdm_out` updates on the clock edge of a `cke` cycle; it is registered with no combinational path from inputs.
- Latency: a sample captured before a frame-start `cke` is `cur` of that frame, and `x` reaches it at the final `cke` of the frame. From capture, that takes ≤ 2·RATE `cke` pulses.
- Sustained throughput: one sample per RATE `cke` pulses. `din_ready` rises one clock after each frame-start `cke`.
- Reset asserted mid-frame: all state returns to reset values on the next edge and any held sample is discarded. The first frame after reset underruns unless a sample is captured before the first `cke`.

## Structure
- Package `ds_pkg`: FB constant (32768, shared with the ADC feedback convention), CLIP, integrator width, sample typedef `logic signed [15:0]`.
- Sub-module `lin_interp` (holding register, phase counter, accumulator, underrun); the top contains the modulator and instantiates `lin_interp`.

## Test plan
- Constant `din = 0`, `cke` every cycle, 1024 `cke` → ones count 512 ± 2; no run of 3 or more equal bits after settling.
- `din = 12288` steady → ones over 1024 `cke` = 704 ± 4; `din = −12288` → 320 ± 4.
- `din = 32767` (clamped to 24576) → 896 ± 4 ones over 1024; integrators never saturate.
- Ramp `din` 0 → 8192, RATE = 8 → probed `x` steps 0, 1024, 2048 … 8192, hitting 8192 exactly at the frame's last `cke`.
- Withhold `din_valid` for one frame → one `underrun` pulse at frame start; `x` stays flat; `din_ready` stays high.
- `cke` every 4th cycle with `din_valid` held high → one capture per 32 clocks. Assert `rst` mid-frame → `pdm_out` = 0, `din_ready` = 1 next cycle.

Source files
------------

// File: rtl/ds_pkg.sv
// Shared constants and types for the delta-sigma DAC modulator.
// Feedback level matches the delta-sigma ADC front end.
package ds_pkg;

    localparam int WIDTH = 16;
    localparam int FB    = 32768;
    localparam int CLIP  = 24576;
    localparam int INT_W = 24;

    typedef logic signed [15:0]      sample_t;
    typedef logic signed [INT_W-1:0] integ_t;
    typedef logic signed [INT_W+1:0] integ_wide_t;

    localparam integ_wide_t INT_HI = 26'sd8388607;
    localparam integ_wide_t INT_LO = -26'sd8388608;

    // Limit a sample to +/-lim so the modulator stays stable.
    function automatic sample_t clamp_sample(input sample_t s, input sample_t lim);
        sample_t neg;
        neg = -lim;
        if (s > lim)
            return lim;
        else if (s < neg)
            return neg;
        else
            return s;
    endfunction

    // Saturate a widened integrator sum back into integrator range.
    function automatic integ_t sat_int(input integ_wide_t v);
        if (v > INT_HI)
            return integ_t'(INT_HI);
        else if (v < INT_LO)
            return integ_t'(INT_LO);
        else
            return integ_t'(v);
    endfunction

endpackage

// File: rtl/lin_interp.sv
// Frame-rate to bit-rate bridge: one-entry holding register,
// phase counter and exact linear interpolation accumulator.
module lin_interp
    import ds_pkg::*;
#(
    parameter int RATE    = 8,
    parameter int CLIP_LV = 24576
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    cke,
    input  sample_t din,
    input  logic    din_valid,
    output logic    din_ready,
    output logic    underrun,
    output sample_t x
);

    localparam int L     = $clog2(RATE);
    localparam int ACC_W = 24;

    localparam sample_t CLIP_S = sample_t'(CLIP_LV);

    sample_t                   r_held;
    logic                      r_full;
    logic [L-1:0]              r_ph;
    sample_t                   r_cur;
    logic signed [16:0]        r_diff;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_underrun;

    logic                      w_cap;
    logic                      w_start;
    logic                      w_take;
    sample_t                   w_cur_n;
    logic signed [16:0]        w_diff_n;
    logic signed [ACC_W-1:0]   w_base;

    assign w_cap    = din_valid && !r_full;
    assign w_start  = cke && (r_ph == '0);
    assign w_take   = w_start && r_full;
    assign w_cur_n  = w_take ? r_held : r_cur;
    assign w_diff_n = 17'(w_cur_n) - 17'(r_cur);
    assign w_base   = ACC_W'(r_cur) <<< L;

    // Holding register, frame sequencing and interpolation state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held     <= '0;
            r_full     <= 1'b0;
            r_ph       <= '0;
            r_cur      <= '0;
            r_diff     <= '0;
            r_acc      <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_cap) begin
                r_held <= clamp_sample(din, CLIP_S);
                r_full <= 1'b1;
            end else if (w_take) begin
                r_full <= 1'b0;
            end
            r_underrun <= w_start && !r_full;
            if (cke) begin
                r_ph <= r_ph + 1'b1;
                if (w_start) begin
                    r_cur  <= w_cur_n;
                    r_diff <= w_diff_n;
                    r_acc  <= w_base + ACC_W'(w_diff_n);
                end else begin
                    r_acc  <= r_acc + ACC_W'(r_diff);
                end
            end
        end
    end

    assign din_ready = !r_full;
    assign underrun  = r_underrun;
    assign x         = sample_t'(r_acc >>> L);

endmodule

// File: rtl/ds_mod_da.sv
// Delta-sigma DAC: linear interpolator feeding a 2nd-order
// CIFB modulator that emits one PDM bit per cke.
module ds_mod_da
    import ds_pkg::*;
#(
    parameter int RATE  = 8,
    parameter int WIDTH = 16,
    parameter int CLIP  = 24576
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cke,
    input  logic signed [WIDTH-1:0] din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic                    pdm_out,
    output logic                    underrun
);

    localparam integ_wide_t FB_W = integ_wide_t'(FB);

    sample_t     w_x;
    integ_wide_t w_fb;
    integ_wide_t w_s1;
    integ_wide_t w_s2;
    integ_t      w_i1n;
    integ_t      w_i2n;

    integ_t      r_i1;
    integ_t      r_i2;
    logic        r_pdm;

    lin_interp #(
        .RATE    (RATE),
        .CLIP_LV (CLIP)
    ) u_interp (
        .clk       (clk),
        .rst       (rst),
        .cke       (cke),
        .din       (sample_t'(din)),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .underrun  (underrun),
        .x         (w_x)
    );

    assign w_fb  = r_pdm ? FB_W : -FB_W;
    assign w_s1  = integ_wide_t'(r_i1) + integ_wide_t'(w_x) - w_fb;
    assign w_i1n = sat_int(w_s1);
    assign w_s2  = integ_wide_t'(r_i2) + integ_wide_t'(w_i1n) - w_fb;
    assign w_i2n = sat_int(w_s2);

    // Integrators and quantizer advance only on bit-rate enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i1  <= '0;
            r_i2  <= '0;
            r_pdm <= 1'b0;
        end else if (cke) begin
            r_i1  <= w_i1n;
            r_i2  <= w_i2n;
            r_pdm <= !w_i2n[INT_W-1];
        end
    end

    assign pdm_out = r_pdm;

endmodule
